// File: rtl/lcd_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | lcd_pkg: panel geometry defaults and pixel-FIFO command word layout      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package lcd_pkg;

  localparam int LCD_H_RES          = 320;
  localparam int LCD_V_RES          = 240;
  localparam int LCD_ADDR_W         = 18;

  localparam int LCD_CMD_ADDR_LSB   = 0;
  localparam int LCD_CMD_ADDR_W     = 18;
  localparam int LCD_CMD_COUNT_LSB  = 18;
  localparam int LCD_CMD_COUNT_W    = 10;
  localparam int LCD_CMD_PAGE_LSB   = 28;
  localparam int LCD_CMD_PAGE_W     = 2;
  localparam int LCD_CMD_PIXEL_BIT  = 30;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLIP = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } fill_state_e;

  // count is run length minus one; the consumer writes count+1 pixels
  function automatic logic [31:0] pack_pfifo_cmd(
    input logic                       pixel,
    input logic [LCD_CMD_PAGE_W-1:0]  page,
    input logic [LCD_CMD_COUNT_W-1:0] count,
    input logic [LCD_CMD_ADDR_W-1:0]  addr
  );
    logic [31:0] cmd;
    cmd = '0;
    cmd[LCD_CMD_PIXEL_BIT]                     = pixel;
    cmd[LCD_CMD_PAGE_LSB +: LCD_CMD_PAGE_W]    = page;
    cmd[LCD_CMD_COUNT_LSB +: LCD_CMD_COUNT_W]  = count;
    cmd[LCD_CMD_ADDR_LSB +: LCD_CMD_ADDR_W]    = addr;
    return cmd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_rect_fill_gen.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | lcd_rect_fill_gen: clips a rectangle fill and emits one run word per row |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module lcd_rect_fill_gen
  import lcd_pkg::*;
#(
  parameter int G_H_RES  = LCD_H_RES,
  parameter int G_V_RES  = LCD_V_RES,
  parameter int G_ADDR_W = LCD_ADDR_W
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        abort_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [8:0]  req_x_i,
  input  logic [7:0]  req_y_i,
  input  logic [8:0]  req_w_i,
  input  logic [7:0]  req_h_i,
  input  logic [1:0]  req_page_i,
  input  logic        req_pixel_i,
  output logic        pfifo_we_o,
  input  logic        pfifo_full_i,
  output logic [31:0] pfifo_data_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [8:0]          H_RES_C  = 9'(G_H_RES);
  localparam logic [7:0]          V_RES_C  = 8'(G_V_RES);
  localparam logic [G_ADDR_W-1:0] STRIDE_C = G_ADDR_W'(G_H_RES);

  fill_state_e         state_q, state_d;
  logic [8:0]          x_q, x_d;
  logic [7:0]          y_q, y_d;
  logic [8:0]          w_q, w_d;
  logic [7:0]          h_q, h_d;
  logic [1:0]          page_q, page_d;
  logic                pixel_q, pixel_d;
  logic [9:0]          count_q, count_d;
  logic [G_ADDR_W-1:0] row_addr_q, row_addr_d;
  logic [7:0]          lines_left_q, lines_left_d;
  logic [31:0]         data_q, data_d;

  logic [8:0]          w_rem;
  logic [7:0]          h_rem;
  logic [8:0]          w_eff;
  logic [7:0]          h_eff;
  logic [G_ADDR_W-1:0] base_addr;
  logic [G_ADDR_W-1:0] next_addr;
  logic                we;

  assign w_rem     = H_RES_C - x_q;
  assign h_rem     = V_RES_C - y_q;
  assign w_eff     = (w_q < w_rem) ? w_q : w_rem;
  assign h_eff     = (h_q < h_rem) ? h_q : h_rem;
  // constant multiply by the stride; synthesis reduces it to shift-add
  assign base_addr = G_ADDR_W'(y_q) * STRIDE_C + G_ADDR_W'(x_q);
  assign next_addr = row_addr_q + STRIDE_C;
  assign we        = (state_q == ST_EMIT) && !pfifo_full_i;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    w_d          = w_q;
    h_d          = h_q;
    page_d       = page_q;
    pixel_d      = pixel_q;
    count_d      = count_q;
    row_addr_d   = row_addr_q;
    lines_left_d = lines_left_q;
    data_d       = data_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          x_d     = req_x_i;
          y_d     = req_y_i;
          w_d     = req_w_i;
          h_d     = req_h_i;
          page_d  = req_page_i;
          pixel_d = req_pixel_i;
          state_d = ST_CLIP;
        end
      end
      ST_CLIP: begin
        if (x_q >= H_RES_C || y_q >= V_RES_C || w_q == '0 || h_q == '0) begin
          state_d = ST_DONE;
        end else begin
          count_d      = {1'b0, w_eff} - 10'd1;
          row_addr_d   = base_addr;
          lines_left_d = h_eff;
          data_d       = pack_pfifo_cmd(pixel_q, page_q, {1'b0, w_eff} - 10'd1,
                                        LCD_CMD_ADDR_W'(base_addr));
          state_d      = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (we) begin
          row_addr_d   = next_addr;
          lines_left_d = lines_left_q - 8'd1;
          data_d       = pack_pfifo_cmd(pixel_q, page_q, count_q,
                                        LCD_CMD_ADDR_W'(next_addr));
          if (lines_left_q == 8'd1) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // abort wins over the state transition but not over this cycle's write
    if (abort_i && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      w_q          <= '0;
      h_q          <= '0;
      page_q       <= '0;
      pixel_q      <= 1'b0;
      count_q      <= '0;
      row_addr_q   <= '0;
      lines_left_q <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      w_q          <= w_d;
      h_q          <= h_d;
      page_q       <= page_d;
      pixel_q      <= pixel_d;
      count_q      <= count_d;
      row_addr_q   <= row_addr_d;
      lines_left_q <= lines_left_d;
      data_q       <= data_d;
    end
  end

  assign req_ready_o  = (state_q == ST_IDLE);
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);
  assign pfifo_we_o   = we;
  assign pfifo_data_o = data_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_rect_fill_gen.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_lcd_rect_fill_gen: directed self-checking bench for lcd_rect_fill_gen |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_lcd_rect_fill_gen;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        abort_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [8:0]  req_x_i = '0;
  logic [7:0]  req_y_i = '0;
  logic [8:0]  req_w_i = '0;
  logic [7:0]  req_h_i = '0;
  logic [1:0]  req_page_i = '0;
  logic        req_pixel_i = 1'b0;
  logic        pfifo_we_o;
  logic        pfifo_full_i = 1'b0;
  logic [31:0] pfifo_data_o;
  logic        busy_o;
  logic        done_o;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] words[$];
  int          done_cyc;
  int          first_cyc;
  int          viol;
  bit          rand_full = 1'b0;

  lcd_rect_fill_gen dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .abort_i      (abort_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_x_i      (req_x_i),
    .req_y_i      (req_y_i),
    .req_w_i      (req_w_i),
    .req_h_i      (req_h_i),
    .req_page_i   (req_page_i),
    .req_pixel_i  (req_pixel_i),
    .pfifo_we_o   (pfifo_we_o),
    .pfifo_full_i (pfifo_full_i),
    .pfifo_data_o (pfifo_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Handshake happens on the posedge inside this task; returns at the
  // following negedge, i.e. in cycle N+1.
  task automatic send_req(input logic [8:0] x, input logic [7:0] y,
                          input logic [8:0] w, input logic [7:0] h,
                          input logic [1:0] page, input logic pixel);
    @(negedge clk_i);
    req_x_i = x; req_y_i = y; req_w_i = w; req_h_i = h;
    req_page_i = page; req_pixel_i = pixel; req_valid_i = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_at_issue: got %b want 1", req_ready_o);
    end
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  // Cycle 1 is N+1. Collects written words until done_o or budget expiry.
  task automatic collect(input int budget);
    words.delete();
    done_cyc = -1; first_cyc = -1; viol = 0;
    for (int c = 1; c <= budget && done_cyc < 0; c++) begin
      if (c > 1) @(negedge clk_i);
      pfifo_full_i = rand_full ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if (pfifo_we_o && pfifo_full_i) viol++;
      if (pfifo_we_o) begin
        words.push_back(pfifo_data_o);
        if (first_cyc < 0) first_cyc = c;
      end
      if (done_o) done_cyc = c;
    end
    pfifo_full_i = 1'b0;
  endtask

  task automatic check_words(input string name, input logic [31:0] e0,
                             input logic [31:0] e1, input logic [31:0] e2,
                             input int n, input int done_exp);
    logic [31:0] exp_w[3];
    exp_w[0] = e0; exp_w[1] = e1; exp_w[2] = e2;
    checks++;
    if (words.size() != n) begin
      errors++;
      $display("FAIL %s_count: got %0d words want %0d", name, words.size(), n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (i >= words.size() || words[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL %s_word%0d: got %h want %h", name, i,
                 (i < words.size()) ? words[i] : 32'hxxxxxxxx, exp_w[i]);
      end
    end
    checks++;
    if (n > 0 && first_cyc != 2) begin
      errors++;
      $display("FAIL %s_first_latency: got %0d want 2", name, first_cyc);
    end
    checks++;
    if (done_cyc != done_exp) begin
      errors++;
      $display("FAIL %s_done_cycle: got %0d want %0d", name, done_cyc, done_exp);
    end
    @(negedge clk_i);
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_back_idle: ready=%b done=%b busy=%b want 1 0 0",
               name, req_ready_o, done_o, busy_o);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    checks++;
    if (req_ready_o !== 1'b1 || pfifo_we_o !== 1'b0 || pfifo_data_o !== 32'h0 ||
        busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b we=%b data=%h busy=%b done=%b want 1 0 0 0 0",
               req_ready_o, pfifo_we_o, pfifo_data_o, busy_o, done_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_basic();
    send_req(9'd10, 8'd2, 9'd5, 8'd3, 2'd1, 1'b1);
    collect(50);
    check_words("basic", 32'h5010028A, 32'h501003CA, 32'h5010050A, 3, 5);
  endtask

  task automatic test_clip();
    send_req(9'd300, 8'd238, 9'd50, 8'd10, 2'd0, 1'b0);
    collect(50);
    check_words("clip", 32'h004D2AAC, 32'h004D2BEC, 32'h0, 2, 4);
  endtask

  task automatic test_full_screen();
    int bad;
    bad = 0;
    rand_full = 1'b1;
    send_req(9'd0, 8'd0, 9'd320, 8'd240, 2'd2, 1'b1);
    collect(3000);
    rand_full = 1'b0;
    checks++;
    if (words.size() != 240) begin
      errors++;
      $display("FAIL full_count: got %0d words want 240", words.size());
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL full_we_while_full: got %0d writes while full want 0", viol);
    end
    for (int i = 0; i < words.size(); i++) begin
      if (words[i][17:0] != 18'(i * 320) || words[i][27:18] != 10'd319 ||
          words[i][31:28] != 4'b0110) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL full_sequence: got %0d bad/duplicated words want 0", bad);
    end
    checks++;
    if (words.size() == 0 || words[words.size()-1] !== 32'h64FD2AC0) begin
      errors++;
      $display("FAIL full_last_word: got %h want 64fd2ac0",
               (words.size() > 0) ? words[words.size()-1] : 32'hxxxxxxxx);
    end
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL full_done: got no done_o want done_o within budget");
    end
    @(negedge clk_i);
  endtask

  task automatic test_degenerate();
    send_req(9'd10, 8'd10, 9'd0, 8'd5, 2'd0, 1'b1);
    collect(20);
    check_words("degen_w0", 32'h0, 32'h0, 32'h0, 0, 2);
    send_req(9'd320, 8'd10, 9'd5, 8'd5, 2'd0, 1'b1);
    collect(20);
    check_words("degen_x320", 32'h0, 32'h0, 32'h0, 0, 2);
    send_req(9'd10, 8'd10, 9'd5, 8'd0, 2'd0, 1'b1);
    collect(20);
    check_words("degen_h0", 32'h0, 32'h0, 32'h0, 0, 2);
    send_req(9'd0, 8'd240, 9'd5, 8'd5, 2'd0, 1'b1);
    collect(20);
    check_words("degen_y240", 32'h0, 32'h0, 32'h0, 0, 2);
  endtask

  task automatic test_abort();
    int dones;
    dones = 0;
    send_req(9'd0, 8'd0, 9'd4, 8'd10, 2'd2, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    abort_i = 1'b1;
    #1;
    checks++;
    if (pfifo_we_o !== 1'b1 || pfifo_data_o !== 32'h200C0140) begin
      errors++;
      $display("FAIL abort_row2: we=%b data=%h want 1 200c0140", pfifo_we_o, pfifo_data_o);
    end
    @(negedge clk_i);
    abort_i = 1'b0;
    #1;
    checks++;
    if (pfifo_we_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle: we=%b busy=%b done=%b ready=%b want 0 0 0 1",
               pfifo_we_o, busy_o, done_o, req_ready_o);
    end
    repeat (4) begin
      @(negedge clk_i);
      #1;
      if (done_o || pfifo_we_o) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d done/we cycles want 0", dones);
    end
    send_req(9'd5, 8'd1, 9'd2, 8'd2, 2'd3, 1'b1);
    collect(50);
    check_words("after_abort", 32'h70040145, 32'h70040285, 32'h0, 2, 4);
  endtask

  task automatic test_async_reset();
    send_req(9'd0, 8'd0, 9'd8, 8'd10, 2'd1, 1'b1);
    @(negedge clk_i);
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if (pfifo_we_o !== 1'b0 || busy_o !== 1'b0 || pfifo_data_o !== 32'h0 ||
        done_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: we=%b busy=%b data=%h done=%b ready=%b want 0 0 0 0 1",
               pfifo_we_o, busy_o, pfifo_data_o, done_o, req_ready_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    send_req(9'd10, 8'd2, 9'd5, 8'd3, 2'd1, 1'b1);
    collect(50);
    check_words("after_reset", 32'h5010028A, 32'h501003CA, 32'h5010050A, 3, 5);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_full_screen();
    test_degenerate();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
